// File: rtl/fp2fix_conv_arbiter_if.sv
// Bus bundle between the requesters/converter (master side) and the arbiter (slave side).
// REQ is a level held with REQ_DATA until GNT; GNT and DONE are 1-cycle pulses; CONV_BEGIN pulses once and CONV_ACK stays high until CONV_RST.
interface fp2fix_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W_FLT = 32,
  parameter int W_FIX = 32
);
  logic [N_REQ-1:0]       REQ;
  logic [N_REQ*W_FLT-1:0] REQ_DATA;
  logic [N_REQ-1:0]       GNT;
  logic [N_REQ-1:0]       DONE;
  logic [W_FIX-1:0]       RESULT;
  logic                   ERR;
  logic                   BUSY;
  logic                   CONV_BEGIN;
  logic [W_FLT-1:0]       CONV_DATA;
  logic                   CONV_RST;
  logic                   CONV_ACK;
  logic [W_FIX-1:0]       CONV_RESULT;

  modport master (
    output REQ, REQ_DATA, CONV_ACK, CONV_RESULT,
    input  GNT, DONE, RESULT, ERR, BUSY, CONV_BEGIN, CONV_DATA, CONV_RST
  );

  modport slave (
    input  REQ, REQ_DATA, CONV_ACK, CONV_RESULT,
    output GNT, DONE, RESULT, ERR, BUSY, CONV_BEGIN, CONV_DATA, CONV_RST
  );
endinterface

// File: rtl/fp2fix_conv_arbiter.sv
// Round-robin sequencer sharing one float-to-fixed converter among N_REQ requesters.
// Optional watchdog abort in WAIT is built only when FP2FIX_ARB_TIMEOUT_EN is defined.
module fp2fix_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W_FLT   = 32,
  parameter int W_FIX   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RST_FF,
  fp2fix_conv_arbiter_if.slave bus,
  output logic [2:0]           dbg_state
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    owner, owner_nxt;
  logic [N_REQ-1:0] gnt, gnt_nxt;
  logic [N_REQ-1:0] done, done_nxt;
  logic [W_FIX-1:0] result, result_nxt;
  logic [W_FLT-1:0] data, data_nxt;
  logic             busy, busy_nxt;
  logic             conv_begin, conv_begin_nxt;
  logic             conv_rst, conv_rst_nxt;
  logic             win_found;
  logic [PW-1:0]    win_idx;

`ifdef FP2FIX_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
  logic          err, err_nxt;
`endif

  // First asserted request scanning from ptr upward, wrapping at N_REQ.
  always_comb begin : arb_scan
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!win_found && bus.REQ[PW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Next-state logic; every output is registered from its *_nxt value.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    owner_nxt      = owner;
    gnt_nxt        = '0;
    done_nxt       = '0;
    result_nxt     = result;
    data_nxt       = data;
    conv_begin_nxt = 1'b0;
    conv_rst_nxt   = 1'b0;
`ifdef FP2FIX_ARB_TIMEOUT_EN
    wd_cnt_nxt     = wd_cnt;
    err_nxt        = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt        = S_GRANT;
          owner_nxt        = win_idx;
          gnt_nxt[win_idx] = 1'b1;
          data_nxt         = bus.REQ_DATA[int'(win_idx)*W_FLT +: W_FLT];
        end
      end
      S_GRANT: begin
        state_nxt      = S_START;
        conv_begin_nxt = 1'b1;
      end
      S_START: begin
        state_nxt = S_WAIT;
`ifdef FP2FIX_ARB_TIMEOUT_EN
        wd_cnt_nxt = '0;
`endif
      end
      S_WAIT: begin
        if (bus.CONV_ACK) begin
          state_nxt       = S_CAPTURE;
          result_nxt      = bus.CONV_RESULT;
          done_nxt[owner] = 1'b1;
        end
`ifdef FP2FIX_ARB_TIMEOUT_EN
        else if (wd_cnt == CW'(TIMEOUT - 1)) begin
          state_nxt       = S_CAPTURE;
          result_nxt      = '0;
          done_nxt[owner] = 1'b1;
          err_nxt         = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
`endif
      end
      S_CAPTURE: begin
        state_nxt    = S_RELEASE;
        conv_rst_nxt = 1'b1;
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
        ptr_nxt   = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      gnt        <= '0;
      done       <= '0;
      result     <= '0;
      data       <= '0;
      busy       <= 1'b0;
      conv_begin <= 1'b0;
      conv_rst   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      gnt        <= gnt_nxt;
      done       <= done_nxt;
      result     <= result_nxt;
      data       <= data_nxt;
      busy       <= busy_nxt;
      conv_begin <= conv_begin_nxt;
      conv_rst   <= conv_rst_nxt;
    end
  end

`ifdef FP2FIX_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      err    <= err_nxt;
    end
  end
  assign bus.ERR = err;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.GNT        = gnt;
  assign bus.DONE       = done;
  assign bus.RESULT     = result;
  assign bus.BUSY       = busy;
  assign bus.CONV_BEGIN = conv_begin;
  assign bus.CONV_DATA  = data;
  assign bus.CONV_RST   = conv_rst;
  assign dbg_state      = state;
endmodule
